// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// pc_fetch_ctrl: fetch-stage PC register, prioritized next-PC selection, buffered redirects.
// Optional macro PC_ALIGN_CHECK_EN enables fetch address error detection (adel_f).  Rev 1.0
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_taken,
  input  logic [31:0] j_target,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        pending,
  output logic        flush,
  output logic        adel_f
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Source class of a buffered redirect; larger value means higher priority.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_J    = 2'd1;
  localparam logic [1:0] SRC_BR   = 2'd2;
  localparam logic [1:0] SRC_ERET = 2'd3;

  state_t      state;
  logic [31:0] pend_target;
  logic [1:0]  pend_src;

  logic        adv;
  logic        live;
  logic        capture;
  logic [1:0]  live_src;
  logic [31:0] live_target;
  logic [31:0] pc_d;
  logic        err_d;

  assign adv = imem_valid & imem_ready & ~stall;

  always_comb begin
    live_src    = SRC_NONE;
    live_target = 32'h0;
    if (eret) begin
      live_src    = SRC_ERET;
      live_target = epc + 32'd4;
    end else if (br_taken) begin
      live_src    = SRC_BR;
      live_target = br_target;
    end else if (j_taken) begin
      live_src    = SRC_J;
      live_target = j_target;
    end
  end

  assign live    = (live_src != SRC_NONE);
  assign capture = live & (~pending | (live_src >= pend_src));

  always_comb begin
    pc_d = pc;
    if (req) begin
      pc_d = HANDLER_PC;
    end else if (state != BOOT && adv) begin
      if (live)         pc_d = live_target;
      else if (pending) pc_d = pend_target;
      else              pc_d = pc + 32'd4;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign err_d = (pc_d[1:0] != 2'b00) || (pc_d < IMEM_LO) || (pc_d > IMEM_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) adel_f <= 1'b0;
    else        adel_f <= err_d;
  end
`else
  assign err_d  = 1'b0;
  assign adel_f = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_valid  <= 1'b0;
      pending     <= 1'b0;
      pend_target <= 32'h0;
      pend_src    <= SRC_NONE;
      flush       <= 1'b0;
    end else begin
      pc         <= pc_d;
      flush      <= req;
      // Every state reachable after a clock issues requests unless the address is illegal.
      imem_valid <= ~err_d;
      if (req) begin
        state   <= RUN;
        pending <= 1'b0;
      end else if (state == BOOT) begin
        state <= RUN;
      end else if (adv) begin
        state   <= RUN;
        pending <= 1'b0;
      end else begin
        if (imem_valid) state <= HOLD;
        if (capture) begin
          pending     <= 1'b1;
          pend_target <= live_target;
          pend_src    <= live_src;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] HPC    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, req = 1'b0, eret = 1'b0, br_taken = 1'b0, j_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] epc = 32'h0, br_target = 32'h0, j_target = 32'h0;
  logic        imem_valid, pending, flush, adel_f;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the observable state
  logic [31:0] m_pc, m_ptgt;
  logic        m_valid, m_pend, m_flush, m_boot;
  int          m_prank;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .j_taken(j_taken), .j_target(j_target),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .pc(pc), .pending(pending),
    .flush(flush), .adel_f(adel_f)
  );

  task automatic model_reset();
    m_pc = RST_PC; m_ptgt = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
    m_flush = 1'b0; m_boot = 1'b1; m_prank = 0;
  endtask

  task automatic clear_inputs();
    req = 1'b0; eret = 1'b0; br_taken = 1'b0; j_taken = 1'b0; stall = 1'b0;
  endtask

  // Advance the model by the rules for the current inputs, then let the DUT take one edge.
  task automatic tick();
    logic        adv;
    int          rank;
    logic [31:0] tgt;
    adv  = m_valid && imem_ready && !stall;
    rank = eret ? 3 : br_taken ? 2 : j_taken ? 1 : 0;
    tgt  = eret ? epc + 32'd4 : br_taken ? br_target : j_target;
    m_flush = req;
    if (req) begin
      m_pc = HPC; m_pend = 1'b0; m_boot = 1'b0; m_valid = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1;
    end else if (adv) begin
      if (rank > 0)    m_pc = tgt;
      else if (m_pend) m_pc = m_ptgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (rank > 0 && (!m_pend || rank >= m_prank)) begin
      m_pend = 1'b1; m_ptgt = tgt; m_prank = rank;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; model_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
    n_cmp++; if (imem_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", imem_valid); end
    n_cmp++; if (pending !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL reset_flags pending=%b flush=%b want 0 0", pending, flush); end
    n_cmp++; if (adel_f !== 1'b0) begin n_err++; $display("FAIL reset_adel got %b want 0", adel_f); end
    reset = 1'b1; imem_ready = 1'b1;
    #1;
    n_cmp++; if (pc !== RST_PC || imem_valid !== 1'b0) begin n_err++; $display("FAIL boot_cycle0 pc=%h valid=%b want %h 0", pc, imem_valid, RST_PC); end
    tick();
    n_cmp++; if (pc !== RST_PC || imem_valid !== 1'b1) begin n_err++; $display("FAIL boot_run pc=%h valid=%b want %h 1", pc, imem_valid, RST_PC); end
    tick();
    n_cmp++; if (pc !== 32'h3004) begin n_err++; $display("FAIL seq_pc1 got %h want 00003004", pc); end
    tick();
    n_cmp++; if (pc !== 32'h3008) begin n_err++; $display("FAIL seq_pc2 got %h want 00003008", pc); end
  endtask

  task automatic test_pending_branch();
    logic [31:0] held;
    held = pc;
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3100;
    tick();
    br_taken = 1'b0;
    tick(); tick();
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL pend_set got %b want 1", pending); end
    n_cmp++; if (pc !== held) begin n_err++; $display("FAIL pend_hold pc=%h want %h", pc, held); end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h3100 || pending !== 1'b0) begin n_err++; $display("FAIL pend_take pc=%h pending=%b want 00003100 0", pc, pending); end
  endtask

  task automatic test_eret_priority();
    imem_ready = 1'b1; eret = 1'b1; epc = 32'h3020; br_taken = 1'b1; br_target = 32'h3100;
    tick();
    clear_inputs();
    n_cmp++; if (pc !== 32'h3024) begin n_err++; $display("FAIL eret_over_br got %h want 00003024", pc); end
    br_taken = 1'b1; br_target = 32'h3400; j_taken = 1'b1; j_target = 32'h3500;
    tick();
    clear_inputs();
    n_cmp++; if (pc !== 32'h3400) begin n_err++; $display("FAIL br_over_j got %h want 00003400", pc); end
  endtask

  task automatic test_wrap();
    eret = 1'b1; epc = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL eret_wrap got %h want 00000000", pc); end
    j_taken = 1'b1; j_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL seq_wrap got %h want 00000000", pc); end
  endtask

  task automatic test_req_bypass();
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3100;
    tick();
    br_taken = 1'b0; stall = 1'b1;
    tick();
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL req_pre_pend got %b want 1", pending); end
    req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if (pc !== HPC || pending !== 1'b0) begin n_err++; $display("FAIL req_load pc=%h pending=%b want %h 0", pc, pending, HPC); end
    n_cmp++; if (flush !== 1'b1 || imem_valid !== 1'b1) begin n_err++; $display("FAIL req_flush flush=%b valid=%b want 1 1", flush, imem_valid); end
    tick();
    n_cmp++; if (flush !== 1'b0 || pc !== HPC) begin n_err++; $display("FAIL req_flush_once flush=%b pc=%h want 0 %h", flush, pc, HPC); end
    clear_inputs(); imem_ready = 1'b1;
  endtask

  task automatic test_pending_overwrite();
    logic [31:0] held;
    held = pc;
    imem_ready = 1'b0; j_taken = 1'b1; j_target = 32'h3200;
    tick();
    j_taken = 1'b0; br_taken = 1'b1; br_target = 32'h3300;
    tick();
    br_taken = 1'b0;
    n_cmp++; if (pending !== 1'b1 || pc !== held) begin n_err++; $display("FAIL ovw_hold pending=%b pc=%h want 1 %h", pending, pc, held); end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h3300) begin n_err++; $display("FAIL ovw_higher got %h want 00003300", pc); end
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3400;
    tick();
    br_taken = 1'b0; j_taken = 1'b1; j_target = 32'h3500;
    tick();
    j_taken = 1'b0; imem_ready = 1'b1;
    tick();
    n_cmp++; if (pc !== 32'h3400) begin n_err++; $display("FAIL ovw_lower_kept got %h want 00003400", pc); end
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3600;
    tick();
    br_taken = 1'b0;
    tick();
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL areset_pre got %b want 1", pending); end
    #2 reset = 1'b0; model_reset();
    #1;
    n_cmp++; if (pc !== RST_PC || pending !== 1'b0 || imem_valid !== 1'b0) begin n_err++; $display("FAIL areset_now pc=%h pending=%b valid=%b want %h 0 0", pc, pending, imem_valid, RST_PC); end
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (pc !== 32'h3004 || pending !== 1'b0) begin n_err++; $display("FAIL areset_discard pc=%h pending=%b want 00003004 0", pc, pending); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      imem_ready = ($urandom % 4) != 0;
      stall      = ($urandom % 5) == 0;
      req        = ($urandom % 25) == 0;
      eret       = ($urandom % 10) == 0;
      br_taken   = ($urandom % 6) == 0;
      j_taken    = ($urandom % 6) == 0;
      epc        = 32'h3000 + ($urandom % 32'h400) * 4;
      br_target  = 32'h3000 + ($urandom % 32'h400) * 4;
      j_target   = 32'h3000 + ($urandom % 32'h400) * 4;
      tick();
      n_cmp++;
      if (pc !== m_pc || imem_valid !== m_valid || pending !== m_pend || flush !== m_flush) begin
        n_err++;
        $display("FAIL rand_%0d pc=%h valid=%b pending=%b flush=%b want %h %b %b %b",
                 i, pc, imem_valid, pending, flush, m_pc, m_valid, m_pend, m_flush);
      end
    end
    clear_inputs(); imem_ready = 1'b1;
    tick();
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_adel();
    imem_ready = 1'b1; j_taken = 1'b1; j_target = 32'h3202;
    tick();
    j_taken = 1'b0;
    n_cmp++; if (adel_f !== 1'b1 || imem_valid !== 1'b0) begin n_err++; $display("FAIL adel_set adel=%b valid=%b want 1 0", adel_f, imem_valid); end
    tick(); tick();
    n_cmp++; if (adel_f !== 1'b1 || imem_valid !== 1'b0 || pc !== 32'h3202) begin n_err++; $display("FAIL adel_hold adel=%b valid=%b pc=%h want 1 0 00003202", adel_f, imem_valid, pc); end
    req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if (adel_f !== 1'b0 || imem_valid !== 1'b1 || pc !== HPC) begin n_err++; $display("FAIL adel_clear adel=%b valid=%b pc=%h want 0 1 %h", adel_f, imem_valid, pc, HPC); end
  endtask
`endif

  initial begin
    test_reset();
    test_pending_branch();
    test_eret_priority();
`ifndef PC_ALIGN_CHECK_EN
    test_wrap();
`endif
    test_req_bypass();
    test_pending_overwrite();
    test_async_reset();
    test_random();
`ifdef PC_ALIGN_CHECK_EN
    test_adel();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
